apb_slave_decoder: RTL
======================

APB_SLAVE_DECODER -- requirements
Module: apb_slave_decoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, the base of a 16 KB window decoded into four 4 KB slave regions.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of ACCESS cycles allowed before the access is aborted (range 2..255).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- s_paddr  in  32  upstream APB address.
- s_psel  in  1  upstream select.
- s_penable  in  1  upstream enable.
- s_pwrite  in  1  upstream write flag.
- s_pwdata  in  32  upstream write data.
- s_prdata  out  32  read data returned upstream.
- s_pready  out  1  ready returned upstream.
- s_pslverr  out  1  error returned upstream (decode miss, timeout, or slave error).
- m_paddr  out  32  broadcast address.
- m_pwrite  out  1  broadcast write flag.
- m_pwdata  out  32  broadcast write data.
- m_penable  out  1  broadcast enable.
- m_psel  out  4  one-hot slave select.
- m_prdata  in  128  slave read data; slave k occupies bits [32k+31:32k].
- m_pready  in  4  per-slave ready.
- m_pslverr  in  4  per-slave error.
- err_count  out  8  saturating count of errored transfers.

Function
REQ-004 SHALL decode a hit when s_paddr[31:14]==BASE_ADDR[31:14]; slave index = s_paddr[13:12]; any other address SHALL be a miss.
REQ-005 SHALL implement FSM IDLE, ACCESS, ERR, ABORT.
REQ-006 IDLE: on s_psel=1 and s_penable=0 (SETUP), SHALL register the hit flag and the index.
- Hit -> ACCESS; miss -> ERR.
REQ-007 During the SETUP cycle, SHALL drive m_psel[idx]=1 combinationally on a hit, with m_penable=0.
REQ-008 m_paddr, m_pwrite and m_pwdata SHALL pass through s_paddr, s_pwrite and s_pwdata combinationally.
REQ-009 ACCESS: SHALL hold the one-hot m_psel of the registered index and drive m_penable=s_penable.
- Upstream signals SHALL be m_prdata[idx], m_pready[idx] and m_pslverr[idx].
- On m_pready[idx]=1, SHALL return to IDLE in the next cycle.
REQ-010 ACCESS SHALL count cycles with m_pready[idx]=0 using an 8-bit counter cleared on SETUP.
- When the count reaches TIMEOUT_CYCLES-1 with ready still low -> ABORT.
REQ-011 ERR (miss) SHALL last exactly one cycle and drive s_pready=1, s_pslverr=1, s_prdata=0 and m_psel=0; the next state SHALL be IDLE.
REQ-012 ABORT SHALL last one cycle and drive m_psel=0, m_penable=0, s_pready=1, s_pslverr=1 and s_prdata=32'hDEAD_0001; the next state SHALL be IDLE.
REQ-013 In IDLE, SHALL drive s_pready=0, s_pslverr=0, s_prdata=0 and m_psel=0 (except as REQ-007).
REQ-014 err_count SHALL increment by 1 when s_pready&s_pslverr=1 in a cycle, saturating at 255.
REQ-015 If s_psel falls during ACCESS (upstream protocol violation), SHALL return to IDLE next cycle with no error and no count increment.
REQ-016 Back-to-back transfers SHALL be accepted: a SETUP in the cycle after completion SHALL be decoded normally, with no idle cycle inserted.
REQ-017 A slave asserting ready in the same cycle the timeout threshold is reached SHALL win: a normal completion, no ABORT.

Reset
REQ-018 On resetn=0, asynchronously: FSM=IDLE, index=0, timeout counter=0, err_count=0; all outputs are at their IDLE values.
REQ-019 Reset mid-transfer SHALL drop m_psel and s_pready immediately, and no completion SHALL be reported.

Structure
REQ-020 The shared package SHALL hold the FSM state encoding, NUM_SLV=4, REGION_BITS=12 and the ABORT_RDATA constant.
REQ-021 SHALL contain one sub-module, apb_timeout_ctr: an 8-bit counter with clear/enable inputs and a threshold-reached output.

Verification
REQ-022 Write 32'h1234_5678 to 0x4000_1004, slave 1 with ready after 2 wait states -> m_psel=4'b0010 and s_pready after the 3rd ACCESS cycle with pslverr=0.
REQ-023 Read 0x4000_3000 with slave 3 returning 32'hCAFE_F00D and zero waits -> s_prdata=32'hCAFE_F00D in the first ACCESS cycle.
REQ-024 Read 0x5000_0000 -> m_psel stays 0, one-cycle s_pready=1 and pslverr=1 with prdata=0, err_count=1.
REQ-025 Access to slave 2 with ready tied low -> ABORT after 16 ACCESS cycles with s_prdata=32'hDEAD_0001, pslverr=1, m_psel dropped.
REQ-026 300 consecutive misses -> err_count saturates at 255.
REQ-027 Reset asserted in the 3rd ACCESS cycle -> all outputs at IDLE values immediately, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_decoder_pkg.sv
// Shared definitions for the APB slave decoder.
//   state_e      : decoder FSM encoding (IDLE, ACCESS, ERR, ABORT)
//   NUM_SLV      : number of downstream slaves
//   REGION_BITS  : log2 of the per-slave region size (4 KB)
//   IDX_W        : width of the slave index
//   ABORT_RDATA  : read data returned upstream when an access times out
//   idx_onehot() : one-hot select vector for a slave index
package apb_slave_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2,
    ST_ABORT  = 2'd3
  } state_e;

  localparam int          NUM_SLV     = 4;
  localparam int          REGION_BITS = 12;
  localparam int          IDX_W       = 2;
  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_0001;

  function automatic logic [NUM_SLV-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SLV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/apb_slave_decoder_timeout_ctr.sv
// apb_timeout_ctr: 8-bit wait-state counter used to bound an ACCESS phase.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous clear (has priority over en)
//   en          : count one cycle (saturates at 255)
//   thresh      : compare value
//   reached     : current count equals thresh
module apb_timeout_ctr (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] thresh,
  output logic       reached
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached = (cnt_q == thresh);

endmodule

// File: rtl/apb_slave_decoder.sv
// apb_slave_decoder: splits a 16 KB APB window at BASE_ADDR into four 4 KB
// slave regions, routes the selected slave's response upstream, reports
// decode misses and access timeouts as errors, and keeps a saturating count
// of errored transfers.
// Ports:
//   clk, resetn               : clock, asynchronous active-low reset
//   s_paddr/psel/penable/pwrite/pwdata : upstream APB request
//   s_prdata/pready/pslverr   : upstream APB response
//   m_paddr/pwrite/pwdata     : broadcast to all slaves (pass-through)
//   m_penable, m_psel[3:0]    : downstream enable and one-hot select
//   m_prdata[127:0]           : slave k read data in bits [32k+31:32k]
//   m_pready[3:0], m_pslverr  : per-slave ready and error
//   err_count                 : saturating count of errored transfers
//
// Handshake: a transfer starts with a SETUP cycle (psel=1, penable=0) seen in
// IDLE; the response is complete in the cycle where s_pready=1, and
// s_pslverr/s_prdata are only meaningful in that cycle.
module apb_slave_decoder
  import apb_slave_decoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          s_paddr,
  input  logic                 s_psel,
  input  logic                 s_penable,
  input  logic                 s_pwrite,
  input  logic [31:0]          s_pwdata,
  output logic [31:0]          s_prdata,
  output logic                 s_pready,
  output logic                 s_pslverr,
  output logic [31:0]          m_paddr,
  output logic                 m_pwrite,
  output logic [31:0]          m_pwdata,
  output logic                 m_penable,
  output logic [NUM_SLV-1:0]   m_psel,
  input  logic [32*NUM_SLV-1:0] m_prdata,
  input  logic [NUM_SLV-1:0]   m_pready,
  input  logic [NUM_SLV-1:0]   m_pslverr,
  output logic [7:0]           err_count
);

  localparam int          HIT_LSB        = REGION_BITS + IDX_W;
  localparam logic [7:0]  TIMEOUT_THRESH = 8'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               setup;
  logic               addr_hit;
  logic [IDX_W-1:0]   addr_idx;
  logic               sel_ready;
  logic               sel_err;
  logic [31:0]        sel_rdata;
  logic               ctr_clr;
  logic               ctr_en;
  logic               ctr_reached;
  logic [NUM_SLV-1:0] m_psel_c;

  assign setup    = s_psel & ~s_penable;
  assign addr_hit = (s_paddr[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB]);
  assign addr_idx = s_paddr[HIT_LSB-1:REGION_BITS];

  assign sel_ready = m_pready[idx_q];
  assign sel_err   = m_pslverr[idx_q];
  assign sel_rdata = m_prdata[{idx_q, 5'd0} +: 32];

  assign m_paddr  = s_paddr;
  assign m_pwrite = s_pwrite;
  assign m_pwdata = s_pwdata;

  apb_timeout_ctr u_timeout_ctr (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .thresh  (TIMEOUT_THRESH),
    .reached (ctr_reached)
  );

  // The hit flag taken at SETUP is carried by the state itself:
  // ACCESS means hit, ERR means miss.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    m_psel_c  = '0;
    m_penable = 1'b0;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = 32'd0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          idx_d   = addr_idx;
          ctr_clr = 1'b1;
          if (addr_hit) begin
            m_psel_c = idx_onehot(addr_idx);
            state_d  = ST_ACCESS;
          end else begin
            state_d  = ST_ERR;
          end
        end
      end

      ST_ACCESS: begin
        m_psel_c  = idx_onehot(idx_q);
        m_penable = s_penable;
        if (!s_psel) begin
          // Master abandoned the transfer: nothing is reported upstream.
          state_d = ST_IDLE;
        end else begin
          s_prdata  = sel_rdata;
          s_pready  = sel_ready;
          s_pslverr = sel_err;
          if (sel_ready) begin
            // Ready wins even on the cycle the threshold is reached.
            state_d = ST_IDLE;
          end else begin
            ctr_en = 1'b1;
            if (ctr_reached) begin
              state_d = ST_ABORT;
            end
          end
        end
      end

      ST_ERR: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_ABORT: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
        s_prdata  = ABORT_RDATA;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The SETUP-cycle select is combinational from s_psel, so it is gated with
  // reset to guarantee no slave is selected while reset is held.
  assign m_psel = resetn ? m_psel_c : '0;

  always_comb begin
    err_count_d = err_count_q;
    if (s_pready && s_pslverr && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
